// File: rtl/rgb_seq_pkg.sv
// -----------------------------------------------------------------------------
// rgb_seq_pkg
//   Shared types and constants for the RGB pattern sequencer:
//     seq_state_t  - playback FSM state
//     rgb_code_t   - one (a,b) colour-code pair as consumed by the RGB decoder
//     STEP_TABLE   - the fixed playback order, entry 0 first
//     CODE_OFF     - code driven whenever playback is not running
// -----------------------------------------------------------------------------
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
    } rgb_code_t;

    localparam rgb_code_t CODE_OFF = '{a: 2'b00, b: 2'b00};

    // Colour-code pairs in playback order.
    localparam rgb_code_t STEP_TABLE [8] = '{
        '{a: 2'b00, b: 2'b00},
        '{a: 2'b01, b: 2'b00},
        '{a: 2'b10, b: 2'b00},
        '{a: 2'b11, b: 2'b00},
        '{a: 2'b00, b: 2'b01},
        '{a: 2'b00, b: 2'b10},
        '{a: 2'b00, b: 2'b11},
        '{a: 2'b11, b: 2'b11}
    };

endpackage

// File: rtl/rgb_pattern_sequencer_if.sv
// -----------------------------------------------------------------------------
// rgb_pattern_sequencer_if
//   Control and colour-code bundle of the RGB pattern sequencer.
//     start_i, stop_i, loop_en_i, dwell_i : playback control (from board/host)
//     a_o, b_o                            : colour code to the RGB decoder
//     step_o, busy_o, done_o              : playback status
//   master : the controlling side (drives control, observes outputs)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface rgb_pattern_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start_i;
    logic               stop_i;
    logic               loop_en_i;
    logic [DWELL_W-1:0] dwell_i;
    logic [1:0]         a_o;
    logic [1:0]         b_o;
    logic [2:0]         step_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output start_i, stop_i, loop_en_i, dwell_i,
        input  a_o, b_o, step_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stop_i, loop_en_i, dwell_i,
        output a_o, b_o, step_o, busy_o, done_o
    );
endinterface

// File: rtl/rgb_pattern_sequencer_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
//   Loadable down-counter that measures how long a step is held.
//     clk, rst_n : clock, asynchronous active-low reset
//     load_i     : load value_i this cycle (takes priority over counting)
//     en_i       : count down by one per cycle while non-zero
//     value_i    : load value
//     zero_o     : counter currently at zero (last cycle of the step)
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples the
    // values from before the edge; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rgb_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_pattern_sequencer
//   Steps the RGB decoder's a/b colour-code inputs through STEP_TABLE, holding
//   each entry for max(dwell_i,1) cycles, either once (done_o pulse at the end)
//   or looping while loop_en_i is high.
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : control inputs and registered outputs (slave modport)
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module rgb_pattern_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int N_STEPS = 8,
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rgb_pattern_sequencer_if.slave   bus
);

    localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

    seq_state_t         state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    rgb_code_t          code_q, code_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_value;
    logic               tmr_zero;
    logic [DWELL_W-1:0] dwell_sat;

    // A dwell of 0 behaves as 1 so every step is visible at least one cycle.
    assign dwell_sat = (bus.dwell_i == '0) ? DWELL_W'(1) : bus.dwell_i;

    dwell_timer #(
        .WIDTH (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .en_i    (state_q == RUN),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    // State register (plus the step index and latched dwell it travels with).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            dwell_q <= DWELL_W'(1);
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
        end
    end

    // Next-state logic. stop_i wins over everything, including the transition
    // into DONE, so an abort on the final cycle never produces done_o.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        step_d    = step_q;
        dwell_d   = dwell_q;
        tmr_load  = 1'b0;
        tmr_value = dwell_q - DWELL_W'(1);

        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.stop_i) begin
                    state_d   = RUN;
                    step_d    = '0;
                    dwell_d   = dwell_sat;
                    tmr_load  = 1'b1;
                    tmr_value = dwell_sat - DWELL_W'(1);
                end
            end
            RUN: begin
                if (bus.stop_i) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else if (tmr_zero) begin
                    if (step_q != LAST_STEP) begin
                        step_d   = step_q + 3'd1;
                        tmr_load = 1'b1;
                    end else if (bus.loop_en_i) begin
                        step_d   = '0;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = DONE;
                        step_d  = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Output logic: decoded from the upcoming state so the registered outputs
    // change on the same edge as the state itself.
    always_comb begin
        code_d = CODE_OFF;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            RUN:     begin
                code_d = STEP_TABLE[step_d];
                busy_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= CODE_OFF;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            code_q <= code_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.a_o    = code_q.a;
    assign bus.b_o    = code_q.b;
    assign bus.step_o = step_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;

endmodule

// File: tb/tb_rgb_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rgb_pattern_sequencer
//   Directed bench for rgb_pattern_sequencer. Expected per-cycle output words
//   {a,b,step,busy,done} are queued when stimulus is applied and compared one
//   per clock, sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rgb_pattern_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rgb_pattern_sequencer_if #(.DWELL_W(8)) bus ();

    rgb_pattern_sequencer #(
        .N_STEPS (8),
        .DWELL_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] sb [$];

    // Reference step table, written out independently of the design package.
    logic [1:0] tab_a [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    logic [1:0] tab_b [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};

    task automatic push_exp(input logic [1:0] a, input logic [1:0] b,
                            input logic [2:0] s, input logic busy, input logic done);
        sb.push_back({a, b, s, busy, done});
    endtask

    task automatic push_idle(input int n);
        repeat (n) push_exp(2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic push_done();
        push_exp(2'b00, 2'b00, 3'd0, 1'b0, 1'b1);
    endtask

    // One full pass at dwell d, truncated to the first lim cycles.
    task automatic push_pass(input int d, input int lim);
        int k;
        k = 0;
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < d; c++) begin
                if (k < lim) push_exp(tab_a[s], tab_b[s], 3'(s), 1'b1, 1'b0);
                k++;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [8:0] obs;
        logic [8:0] exp;
        checks++;
        obs = {bus.a_o, bus.b_o, bus.step_o, bus.busy_o, bus.done_o};
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty, observed %b", tag, obs);
        end
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed a,b,step,busy,done=%b expected %b (t=%0t)",
                       tag, obs, exp, $time);
            end
        end
    endtask

    task automatic expect_cycles(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i   = 1'b0;
        bus.stop_i    = 1'b0;
        bus.loop_en_i = 1'b0;
        bus.dwell_i   = 8'd0;

        // Reset values.
        #2;
        push_idle(1);
        check("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(2);
        expect_cycles(2, "idle_after_reset");

        // One-shot, dwell 2: 8 steps x 2 cycles, done at start+16, then off.
        bus.dwell_i   = 8'd2;
        bus.loop_en_i = 1'b0;
        bus.start_i   = 1'b1;
        push_pass(2, 16);
        push_done();
        push_idle(2);
        expect_cycles(1, "oneshot_d2");
        bus.start_i = 1'b0;
        expect_cycles(18, "oneshot_d2");

        // Dwell 0 behaves as 1: done at start+8.
        bus.dwell_i = 8'd0;
        bus.start_i = 1'b1;
        push_pass(1, 8);
        push_done();
        expect_cycles(1, "oneshot_d0");
        bus.start_i = 1'b0;
        expect_cycles(8, "oneshot_d0");

        // Now in DONE: start held here is ignored, then accepted in the IDLE
        // cycle that follows (back-to-back run).
        bus.start_i = 1'b1;
        push_idle(1);
        push_pass(1, 8);
        push_done();
        push_idle(1);
        expect_cycles(2, "back_to_back");
        bus.start_i = 1'b0;
        expect_cycles(9, "back_to_back");

        // Looping, dwell 3. start_i and a dwell_i change mid-run are ignored;
        // loop_en_i dropped during pass 2 ends playback after that pass.
        bus.dwell_i   = 8'd3;
        bus.loop_en_i = 1'b1;
        bus.start_i   = 1'b1;
        push_pass(3, 24);
        push_pass(3, 24);
        push_done();
        push_idle(2);
        expect_cycles(1, "loop_pass1");
        bus.start_i = 1'b0;
        expect_cycles(10, "loop_pass1");
        bus.start_i = 1'b1;
        bus.dwell_i = 8'd7;
        expect_cycles(1, "start_during_run");
        bus.start_i = 1'b0;
        expect_cycles(12, "loop_wrap");
        expect_cycles(5, "loop_pass2");
        bus.loop_en_i = 1'b0;
        expect_cycles(22, "loop_end");

        // Abort at step 5: next cycle off, no done_o ever.
        bus.dwell_i = 8'd2;
        bus.start_i = 1'b1;
        push_pass(2, 11);
        push_idle(20);
        expect_cycles(1, "abort_run");
        bus.start_i = 1'b0;
        expect_cycles(10, "abort_run");
        bus.stop_i = 1'b1;
        expect_cycles(1, "abort_stop");
        bus.stop_i = 1'b0;
        expect_cycles(19, "abort_no_done");

        // start_i and stop_i together in IDLE: stays IDLE.
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        push_idle(3);
        expect_cycles(3, "start_stop_idle");
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;

        // stop_i on the very last cycle suppresses the done pulse.
        bus.dwell_i = 8'd1;
        bus.start_i = 1'b1;
        push_pass(1, 8);
        push_idle(4);
        expect_cycles(1, "stop_last_run");
        bus.start_i = 1'b0;
        expect_cycles(7, "stop_last_run");
        bus.stop_i = 1'b1;
        expect_cycles(1, "stop_last_edge");
        bus.stop_i = 1'b0;
        expect_cycles(3, "stop_last_no_done");

        // Asynchronous reset mid-run at step 3.
        bus.dwell_i = 8'd4;
        bus.start_i = 1'b1;
        push_pass(4, 13);
        expect_cycles(1, "reset_run");
        bus.start_i = 1'b0;
        expect_cycles(12, "reset_run");
        rst_n = 1'b0;
        #1;
        push_idle(1);
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(3);
        expect_cycles(3, "after_reset_release");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d leftover entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
